pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline. It supersedes the combinational load-use and forwarding logic in the core controller. It adds:
- multi-cycle EXE operations (multiplier/divider) and variable-latency memory reads, each tracked by its own counter FSM;
- configurable branch flush depth;
- a hardware stall-cycle counter.

It sits beside the instruction decoder. It consumes decoded ID-stage operand usage plus EXE/MEM/WB writeback feedback, and drives all stage enable/reset lines.

## Interface
- `REG_AW`, 5, register address width
- `MUL_LAT`, 4, cycles a multi-cycle op occupies EXE (1..16; 1 = never stalls)
- `MEM_LAT`, 1, cycles a load occupies MEM (1..16; 1 = never stalls)
- `FLUSH_DEPTH`, 1, stages flushed on taken jump/branch (1 = ID, 2 = ID+EXE)
- `CNT_W`, 32, stall counter width
- `clk` in 1: main clock
- `rst_n` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `debug_en`, `debug_step` in 1: debug halt / single-step clock
- `id_rs_addr`, `id_rt_addr` in REG_AW: ID source registers
- `id_rs_used`, `id_rt_used`, `id_is_store` in 1: decoded operand usage
- `exe_wen`, `exe_is_load`, `exe_is_mul` in 1: EXE writeback enable / load / multi-cycle op
- `exe_waddr` in REG_AW: EXE destination
- `mem_wen`, `mem_is_load` in 1; `mem_waddr` in REG_AW: MEM stage feedback
- `jump_en` in 1: taken jump/branch resolved in ID
- `fwd_a`, `fwd_b` out 2: 0 = REG, 1 = EXE_ALU, 2 = MEM_ALU, 3 = MEM_DM
- `mem_fwd_m` out 1: forward load data into store data at MEM
- `if_en`, `id_en`, `exe_en`, `mem_en`, `wb_en` out 1: stage enables
- `if_rst`, `id_rst`, `exe_rst`, `mem_rst`, `wb_rst` out 1: stage bubble/reset
- `mul_busy`, `mem_busy` out 1: counter FSM asserting stall this cycle
- `stall_cycles` out CNT_W: count of cycles with any stall

## Operation
- **Match rule.** A match requires the used flag, equal address, source wen, and address != 0.
- **Forwarding.** For each operand, select in priority order:
  - EXE match with `!exe_is_load` → 1;
  - else MEM match → 3 if `mem_is_load`, else 2;
  - else 0.
- **Store data.** `mem_fwd_m` = rt match against a loading EXE while `id_is_store`.
- **Load-use stall.** An rs match against a loading EXE stalls. An rt match against a loading EXE also stalls, unless `id_is_store`.
- **Multi-cycle FSM** (IDLE/BUSY/DONE), one each for MUL (EXE) and MEM (MEM):
  - IDLE → BUSY when the trigger (`exe_is_mul` / `mem_is_load`) is high and LAT > 1. Stall is asserted in the entry cycle, and cnt loads LAT−2.
  - BUSY with cnt != 0: stall, cnt−−.
  - BUSY with cnt == 0: no stall. Go to IDLE if the stage enable is 1, else DONE.
  - DONE → IDLE when the stage enable is 1. DONE never stalls, so the same instruction is never re-triggered.
  - Counters and FSMs hold while debug-halted.
- **Stall priority and effects** (highest first):
  1. `rst_n` low: all `*_rst` = 1, all `*_en` = 1.
  2. Debug halt, i.e. `debug_en` and no rising edge of `debug_step`: all `*_en` = 0.
  3. `mem_busy`: IF/ID/EXE/MEM enables = 0, `wb_rst` = 1.
  4. `mul_busy`: IF/ID/EXE enables = 0, `mem_rst` = 1.
  5. Load-use: IF/ID enables = 0, `exe_rst` = 1.
  6. `jump_en`: `id_rst` = 1; also `exe_rst` = 1 if FLUSH_DEPTH = 2.
- `jump_en` is ignored in any stall cycle; the branch stays in ID and re-asserts it.
- `stall_cycles` increments once per cycle in which priority 3, 4 or 5 is active and there is no debug halt. It wraps at 2^CNT_W.

## Timing
- Forwarding, stall and enable outputs are combinational from inputs and FSM state.
- FSMs, the counter and `debug_step_prev` update on `posedge clk`.
- On reset: FSMs IDLE, cnt 0, `stall_cycles` 0, `debug_step_prev` 0, `mul_busy` = `mem_busy` = 0.
- With no matches, `fwd_a` = `fwd_b` = 0 and `mem_fwd_m` = 0.
- A multi-cycle op stalls exactly LAT−1 cycles and occupies its stage LAT cycles.
- MUL and MEM counters run concurrently. An overlapped MUL count finishes under a MEM stall, then waits in DONE.
- Load-use adds exactly 1 stall cycle. The following cycle forwards with code 3.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately (asynchronous). No stall is asserted after reset release.

## Test plan
- **ALU chain.** add $3 in EXE, ID uses $3 as rs → `fwd_a` = 1. Next cycle, with $3 in MEM non-load → `fwd_a` = 2. With `exe_waddr` = 0, `fwd_a` = 0.
- **Load-use.** lw $4 in EXE, ID add uses $4 → 1 cycle with `if_en` = `id_en` = 0 and `exe_rst` = 1. Next cycle `fwd_a` = 3. Same case with sw rt=$4 → no stall, `mem_fwd_m` = 1.
- **Multiply, MUL_LAT = 4.** `exe_is_mul` held → `mul_busy` for 3 cycles, `mem_rst` = 1 each cycle, then release. `stall_cycles` = 3.
- **Overlap, MEM_LAT = 3, MUL_LAT = 4.** Load in MEM and mul in EXE on the same cycle → 2 cycles `wb_rst`, then 1 cycle `mem_rst`. `stall_cycles` = 3, and both FSMs end in IDLE.
- **Jump vs stall, FLUSH_DEPTH = 2.** `jump_en` during load-use → no flush. Next cycle → `id_rst` = `exe_rst` = 1.
- **Debug and reset.** `debug_en` = 1 → all enables 0 and counters frozen. One `debug_step` rising edge → exactly one advance cycle. `rst_n` low during BUSY → FSM IDLE and `stall_cycles` = 0 at once.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline feedback / control bundle for pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              debug_en;
    logic              debug_step;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_is_store;
    logic              exe_wen;
    logic              exe_is_load;
    logic              exe_is_mul;
    logic [REG_AW-1:0] exe_waddr;
    logic              mem_wen;
    logic              mem_is_load;
    logic [REG_AW-1:0] mem_waddr;
    logic              jump_en;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_fwd_m;
    logic              if_en;
    logic              id_en;
    logic              exe_en;
    logic              mem_en;
    logic              wb_en;
    logic              if_rst;
    logic              id_rst;
    logic              exe_rst;
    logic              mem_rst;
    logic              wb_rst;
    logic              mul_busy;
    logic              mem_busy;
    logic [CNT_W-1:0]  stall_cycles;

    // decoder/pipeline side: supplies feedback, receives controls
    modport master (
        output debug_en, debug_step,
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_store,
        output exe_wen, exe_is_load, exe_is_mul, exe_waddr,
        output mem_wen, mem_is_load, mem_waddr, jump_en,
        input  fwd_a, fwd_b, mem_fwd_m,
        input  if_en, id_en, exe_en, mem_en, wb_en,
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        input  mul_busy, mem_busy, stall_cycles
    );

    // hazard controller side
    modport slave (
        input  debug_en, debug_step,
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_store,
        input  exe_wen, exe_is_load, exe_is_mul, exe_waddr,
        input  mem_wen, mem_is_load, mem_waddr, jump_en,
        output fwd_a, fwd_b, mem_fwd_m,
        output if_en, id_en, exe_en, mem_en, wb_en,
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        output mul_busy, mem_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding and stall controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MUL_LAT     = 4,
    parameter int MEM_LAT     = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic              MUL_MC   = (MUL_LAT > 1);
    localparam logic              MEM_MC   = (MEM_LAT > 1);
    localparam logic [3:0]        MUL_LOAD = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
    localparam logic [3:0]        MEM_LOAD = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
    localparam logic              FLUSH_EXE = (FLUSH_DEPTH == 2);

    logic [1:0]       mul_state;
    logic [1:0]       mem_state;
    logic [3:0]       mul_cnt;
    logic [3:0]       mem_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             debug_step_prev;

    logic rs_exe, rt_exe, rs_mem, rt_mem;
    logic load_use, mul_stall, mem_stall, halt;
    logic en_if, en_id, en_exe, en_mem, en_wb;
    logic rst_if, rst_id, rst_exe, rst_mem, rst_wb;

    // source-operand match against EXE and MEM writebacks ($0 never matches)
    always_comb begin
        rs_exe = bus.id_rs_used && bus.exe_wen && (bus.exe_waddr == bus.id_rs_addr) && (bus.id_rs_addr != ZERO_REG);
        rt_exe = bus.id_rt_used && bus.exe_wen && (bus.exe_waddr == bus.id_rt_addr) && (bus.id_rt_addr != ZERO_REG);
        rs_mem = bus.id_rs_used && bus.mem_wen && (bus.mem_waddr == bus.id_rs_addr) && (bus.id_rs_addr != ZERO_REG);
        rt_mem = bus.id_rt_used && bus.mem_wen && (bus.mem_waddr == bus.id_rt_addr) && (bus.id_rt_addr != ZERO_REG);
    end

    // forwarding mux selects: youngest ALU result first, then MEM (ALU or load data)
    always_comb begin
        bus.fwd_a = 2'd0;
        bus.fwd_b = 2'd0;
        if (rs_exe && !bus.exe_is_load)
            bus.fwd_a = 2'd1;
        else if (rs_mem)
            bus.fwd_a = bus.mem_is_load ? 2'd3 : 2'd2;
        if (rt_exe && !bus.exe_is_load)
            bus.fwd_b = 2'd1;
        else if (rt_mem)
            bus.fwd_b = bus.mem_is_load ? 2'd3 : 2'd2;
        bus.mem_fwd_m = rt_exe && bus.exe_is_load && bus.id_is_store;
    end

    // stall sources; a store's rt can take load data at MEM, so it does not stall
    always_comb begin
        load_use  = bus.exe_is_load && (rs_exe || (rt_exe && !bus.id_is_store));
        mul_stall = ((mul_state == S_IDLE) && bus.exe_is_mul && MUL_MC) ||
                    ((mul_state == S_BUSY) && (mul_cnt != 4'd0));
        mem_stall = ((mem_state == S_IDLE) && bus.mem_is_load && MEM_MC) ||
                    ((mem_state == S_BUSY) && (mem_cnt != 4'd0));
        halt      = bus.debug_en && !(bus.debug_step && !debug_step_prev);
    end

    // stage enable / bubble generation in priority order
    always_comb begin
        {en_if, en_id, en_exe, en_mem, en_wb}      = 5'b11111;
        {rst_if, rst_id, rst_exe, rst_mem, rst_wb} = 5'b00000;
        if (!rst_n) begin
            {rst_if, rst_id, rst_exe, rst_mem, rst_wb} = 5'b11111;
        end else if (halt) begin
            {en_if, en_id, en_exe, en_mem, en_wb} = 5'b00000;
        end else if (mem_stall) begin
            {en_if, en_id, en_exe, en_mem} = 4'b0000;
            rst_wb = 1'b1;
        end else if (mul_stall) begin
            {en_if, en_id, en_exe} = 3'b000;
            rst_mem = 1'b1;
        end else if (load_use) begin
            {en_if, en_id} = 2'b00;
            rst_exe = 1'b1;
        end else if (bus.jump_en) begin
            rst_id  = 1'b1;
            rst_exe = FLUSH_EXE;
        end
    end

    // drive outputs
    always_comb begin
        bus.if_en        = en_if;
        bus.id_en        = en_id;
        bus.exe_en       = en_exe;
        bus.mem_en       = en_mem;
        bus.wb_en        = en_wb;
        bus.if_rst       = rst_if;
        bus.id_rst       = rst_id;
        bus.exe_rst      = rst_exe;
        bus.mem_rst      = rst_mem;
        bus.wb_rst       = rst_wb;
        bus.mul_busy     = rst_n && mul_stall;
        bus.mem_busy     = rst_n && mem_stall;
        bus.stall_cycles = stall_cnt;
    end

    // multi-cycle EXE tracker; DONE parks a finished op until EXE can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_state <= S_IDLE;
            mul_cnt   <= 4'd0;
        end else if (!halt) begin
            case (mul_state)
                S_IDLE: if (bus.exe_is_mul && MUL_MC) begin
                    mul_state <= S_BUSY;
                    mul_cnt   <= MUL_LOAD;
                end
                S_BUSY: if (mul_cnt != 4'd0) mul_cnt <= mul_cnt - 4'd1;
                        else mul_state <= en_exe ? S_IDLE : S_DONE;
                S_DONE: if (en_exe) mul_state <= S_IDLE;
                default: mul_state <= S_IDLE;
            endcase
        end
    end

    // variable-latency load tracker for the MEM stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state <= S_IDLE;
            mem_cnt   <= 4'd0;
        end else if (!halt) begin
            case (mem_state)
                S_IDLE: if (bus.mem_is_load && MEM_MC) begin
                    mem_state <= S_BUSY;
                    mem_cnt   <= MEM_LOAD;
                end
                S_BUSY: if (mem_cnt != 4'd0) mem_cnt <= mem_cnt - 4'd1;
                        else mem_state <= en_mem ? S_IDLE : S_DONE;
                S_DONE: if (en_mem) mem_state <= S_IDLE;
                default: mem_state <= S_IDLE;
            endcase
        end
    end

    // stall-cycle counter and debug-step edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt       <= '0;
            debug_step_prev <= 1'b0;
        end else begin
            debug_step_prev <= bus.debug_step;
            if (!halt && (mem_stall || mul_stall || load_use))
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end
endmodule
